// File: rtl/riscv_seq_pkg.sv
// riscv_seq_pkg
// Shared definitions for the multi-cycle execution sequencer:
//   - seq_state_e     : sequencer FSM state encoding
//   - CAUSE_*         : mcause codes the sequencer raises
//   - NOP_INSN        : canonical nop (addi x0, x0, 0) loaded into the IR at reset
//   - mem_fault_cause : selects the load/store access-fault code
package riscv_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_TRAP,
        S_HALT
    } seq_state_e;

    localparam logic [3:0] CAUSE_IFETCH_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_IFETCH_FAULT    = 4'd1;
    localparam logic [3:0] CAUSE_LOAD_FAULT      = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT     = 4'd7;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic logic [3:0] mem_fault_cause(input logic is_store);
        return is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
    endfunction

endpackage

// File: rtl/riscv_seq_timeout.sv
// riscv_seq_timeout
// Bus-wait watchdog for the sequencer. Counts cycles spent in a request or
// wait state and flags the cycle in which the wait budget is used up.
// Ports:
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clear_i   : restart the count (asserted on the cycle a state is left/entered)
//   en_i      : sequencer is in a state that waits on a bus
//   expired_o : this is the MAX_WAIT-th consecutive waiting cycle
module riscv_seq_timeout #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment so the first cycle of a new state always
    // starts from zero, even when the previous state was also a waiting one.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count equals the number of cycles already spent waiting, so the
    // budget is exhausted in the cycle where it sits at MAX_WAIT-1.
    assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/riscv_mc_seq.sv
// riscv_mc_seq
// Multi-cycle fetch/execute/memory/writeback sequencer for the RV32 core.
// Owns PC and instruction register, gates architectural writes to the WB
// cycle and raises precise traps for bus errors, bus timeouts and
// misaligned successor PCs.
// Ports:
//   clk_i, rst_ni                     : clock, asynchronous active-low reset
//   imem_req_valid_o/ready_i, addr_o  : fetch request (address = pc)
//   imem_rsp_valid_i/data_i/err_i     : fetch response
//   inst_o, pc_o                      : instruction register, current PC
//   next_pc_i, is_load_i, is_store_i,
//   is_halt_i                         : combinational decode/datapath results
//   dmem_req_valid_o/ready_i          : data request handshake
//   dmem_rsp_valid_i/err_i            : data response
//   reg_wen_gate_o, csr_wen_gate_o    : write-enable gates, high only in WB
//   trap_valid_o/cause_o/epc_o        : one-cycle trap report
//   trap_target_i                     : mtvec
//   halted_o                          : core stopped on ebreak
// Optional (macro RISCV_SEQ_PERF_EN):
//   mcycle_o   : counts every non-HALT cycle
//   minstret_o : counts WB cycles
module riscv_mc_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              MAX_WAIT = 255,
    parameter int              CNT_W    = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic            is_halt_i,
    output logic            dmem_req_valid_o,
    input  logic            dmem_req_ready_i,
    input  logic            dmem_rsp_valid_i,
    input  logic            dmem_rsp_err_i,
    output logic            reg_wen_gate_o,
    output logic            csr_wen_gate_o,
    output logic            trap_valid_o,
    output logic [3:0]      trap_cause_o,
    output logic [XLEN-1:0] trap_epc_o,
    input  logic [XLEN-1:0] trap_target_i,
    output logic            halted_o
`ifdef RISCV_SEQ_PERF_EN
    ,output logic [63:0]    mcycle_o
    ,output logic [63:0]    minstret_o
`endif
);

    import riscv_seq_pkg::*;

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [3:0]      cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            wait_en;
    logic            wait_expired;

    riscv_seq_timeout #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (state_d != state_q),
        .en_i      (wait_en),
        .expired_o (wait_expired)
    );

    // A completed handshake always takes priority over an expiring timeout,
    // so a response arriving in the last allowed cycle is still accepted.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inst_d           = inst_q;
        cause_d          = cause_q;
        epc_d            = epc_q;
        wait_en          = 1'b0;
        imem_req_valid_o = 1'b0;
        dmem_req_valid_o = 1'b0;
        reg_wen_gate_o   = 1'b0;
        csr_wen_gate_o   = 1'b0;
        trap_valid_o     = 1'b0;
        halted_o         = 1'b0;

        case (state_q)
            S_FETCH_REQ: begin
                imem_req_valid_o = 1'b1;
                wait_en          = 1'b1;
                if (imem_req_ready_i) begin
                    state_d = S_FETCH_WAIT;
                end else if (wait_expired) begin
                    cause_d = CAUSE_IFETCH_FAULT;
                    epc_d   = pc_q;
                    state_d = S_TRAP;
                end
            end
            S_FETCH_WAIT: begin
                wait_en = 1'b1;
                if (imem_rsp_valid_i) begin
                    if (imem_rsp_err_i) begin
                        cause_d = CAUSE_IFETCH_FAULT;
                        epc_d   = pc_q;
                        state_d = S_TRAP;
                    end else begin
                        inst_d  = imem_rsp_data_i;
                        state_d = S_EXEC;
                    end
                end else if (wait_expired) begin
                    cause_d = CAUSE_IFETCH_FAULT;
                    epc_d   = pc_q;
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                if (is_halt_i) begin
                    state_d = S_HALT;
                end else if (is_load_i || is_store_i) begin
                    state_d = S_MEM_REQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM_REQ: begin
                dmem_req_valid_o = 1'b1;
                wait_en          = 1'b1;
                if (dmem_req_ready_i) begin
                    state_d = S_MEM_WAIT;
                end else if (wait_expired) begin
                    cause_d = mem_fault_cause(is_store_i);
                    epc_d   = pc_q;
                    state_d = S_TRAP;
                end
            end
            S_MEM_WAIT: begin
                wait_en = 1'b1;
                if (dmem_rsp_valid_i) begin
                    if (dmem_rsp_err_i) begin
                        cause_d = mem_fault_cause(is_store_i);
                        epc_d   = pc_q;
                        state_d = S_TRAP;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    cause_d = mem_fault_cause(is_store_i);
                    epc_d   = pc_q;
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                // The instruction itself retires even when its successor PC
                // is misaligned; the fault belongs to the jump target.
                reg_wen_gate_o = 1'b1;
                csr_wen_gate_o = 1'b1;
                if (next_pc_i[1:0] != 2'b00) begin
                    cause_d = CAUSE_IFETCH_MISALIGN;
                    epc_d   = pc_q;
                    state_d = S_TRAP;
                end else begin
                    pc_d    = next_pc_i;
                    state_d = S_FETCH_REQ;
                end
            end
            S_TRAP: begin
                trap_valid_o = 1'b1;
                pc_d         = trap_target_i & {{(XLEN-2){1'b1}}, 2'b00};
                state_d      = S_FETCH_REQ;
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                state_d = S_FETCH_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INSN;
            cause_q <= 4'd0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign trap_cause_o = cause_q;
    assign trap_epc_o   = epc_q;

`ifdef RISCV_SEQ_PERF_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            if (state_q != S_HALT) begin
                mcycle_q <= mcycle_q + 64'd1;
            end
            if (state_q == S_WB) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    assign mcycle_o   = mcycle_q;
    assign minstret_o = minstret_q;
`endif

endmodule

// File: doc/riscv_mc_seq.md
Name: riscv_mc_seq

Overview:
Multi-cycle execution sequencer for the next-generation RV32 core. It replaces implicit single-cycle timing with an explicit fetch/execute/memory/writeback FSM over valid/ready instruction and data buses. It owns the PC and instruction register, gates regfile/CSR/memory writes to the correct cycle, and raises precise traps for bus faults, timeouts and misaligned fetch targets. The existing decoder, ALU, BCU and CSR file remain combinational around it.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h8000_0000, PC value loaded at reset
MAX_WAIT, 255, max cycles waiting on any bus response before access-fault trap
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  fetch request accepted
imem_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  fetch data valid
imem_rsp_data  in  32  fetched instruction
imem_rsp_err  in  1  fetch bus error (qualified by rsp_valid)
inst  out  32  instruction register
pc  out  XLEN  current PC
next_pc  in  XLEN  datapath-computed successor PC
is_load  in  1  decoded load
is_store  in  1  decoded store
is_halt  in  1  decoded ebreak
dmem_req_valid  out  1  data request
dmem_req_ready  in  1  data request accepted
dmem_rsp_valid  in  1  data response valid
dmem_rsp_err  in  1  data bus error
reg_wen_gate  out  1  AND-ed with RegWr at regfile
csr_wen_gate  out  1  AND-ed with CSR write enables
trap_valid  out  1  one-cycle trap pulse
trap_cause  out  4  mcause code
trap_epc  out  XLEN  faulting PC
trap_target  in  XLEN  mtvec value
halted  out  1  core stopped

Behaviour:
- Reset (rst low, async): state=FETCH_REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), all valid/gate/trap outputs 0, halted 0, timeout counter 0.
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, TRAP, HALT.
- FETCH_REQ: imem_req_valid=1; on imem_req_ready -> FETCH_WAIT. Request held stable until accepted.
- FETCH_WAIT: on imem_rsp_valid & !err: inst<=rsp_data -> EXEC; on err: cause=1 -> TRAP. Response in same cycle as acceptance is not permitted (min latency 1).
- EXEC: one cycle for combinational decode/ALU. is_halt -> HALT; is_load|is_store -> MEM_REQ; else -> WB.
- MEM_REQ/MEM_WAIT: same handshake as fetch on dmem. err -> TRAP with cause 5 (load) or 7 (store).
- WB: reg_wen_gate=1 and csr_wen_gate=1 for exactly this cycle (store: reg gate still 1; decoder's RegWr=0). If next_pc[1:0]!=0: cause=0, trap_epc=pc, no PC update -> TRAP; else pc<=next_pc -> FETCH_REQ. Gates stay 1 in WB even on misalign (instruction retires, target faults).
- Timeout: counter clears on entry to any *_WAIT/*_REQ state, increments each cycle there; reaching MAX_WAIT -> TRAP with cause 1 (fetch) or 5/7 (data). Request dropped; late response ignored until next request.
- TRAP: trap_valid=1 one cycle, trap_cause/trap_epc valid same cycle; pc<=trap_target & ~3 -> FETCH_REQ. Gates 0 (faulting load/store does not write).
- HALT: halted=1, no bus activity, leaves only via reset.
- Mid-transaction async reset abandons outstanding requests; bus owner must tolerate.

Optional Feature:
RISCV_SEQ_PERF_EN: adds outputs mcycle (64b, +1 every non-HALT cycle) and minstret (64b, +1 per WB cycle), both reset to 0. Without macro: ports absent, no counters.

Decomposition:
- Package riscv_seq_pkg: state enum, cause constants (CAUSE_IFETCH_MISALIGN=0, CAUSE_IFETCH_FAULT=1, CAUSE_LOAD_FAULT=5, CAUSE_STORE_FAULT=7), NOP encoding.
- One sub-module: riscv_seq_timeout (clear/enable, CNT_W counter, expired flag at MAX_WAIT).

Test Plan:
- Reset release, imem ready=1, rsp 1 cycle later with addi -> imem_addr=0x8000_0000, reg_wen_gate pulses at cycle 4, pc=0x8000_0004.
- Load with dmem_req_ready delayed 3 cycles, rsp 2 later -> request held stable, single WB pulse, pc advances by 4.
- imem_rsp_err on fetch at 0x8000_0010, trap_target=0x8000_0101 -> trap_valid 1 cycle, cause 1, epc 0x8000_0010, next fetch 0x8000_0100.
- Jump with next_pc=0x8000_0022 -> WB gates 1, then trap cause 0, epc = jump PC.
- dmem never responds, MAX_WAIT=4 -> trap cause 7 for store exactly 4 cycles into wait; late rsp ignored.
- ebreak -> halted=1, no further imem_req_valid for 100 cycles; rst low mid-HALT -> pc=RESET_PC.
